// File: rtl/deser_arb_pkg.sv
// rtl/deser_arb_pkg.sv - shared FSM state type and default sizing for the deserializing arbiter
package deser_arb_pkg;

  localparam int DEF_N_SRC  = 4;
  localparam int DEF_WORD_W = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/deser_shift_core.sv
// rtl/deser_shift_core.sv - MSB-first shift register with accepted-bit counter
module deser_shift_core
  import deser_arb_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              data_bit,
  input  logic              bit_val,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int CNT_W = $clog2(WORD_W);

  // Only WORD_W-1 bits are stored; the final bit is taken straight from the
  // input so the completed word is available on the edge that accepts it.
  logic [WORD_W-2:0] shreg;
  logic [CNT_W-1:0]  cnt;

  assign word      = {shreg, data_bit};
  assign word_done = bit_val && (cnt == CNT_W'(WORD_W - 1));

  // Shift in each accepted bit at the LSB; restart counting after a full word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (bit_val) begin
      shreg <= word[WORD_W-2:0];
      cnt   <= word_done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/deser_arbiter.sv
// rtl/deser_arbiter.sv - round-robin arbiter that deserializes one word from the granted source
module deser_arbiter
  import deser_arb_pkg::*;
#(
  parameter int N_SRC  = DEF_N_SRC,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [N_SRC-1:0]         req_i,
  input  logic [N_SRC-1:0]         data_i,
  input  logic [N_SRC-1:0]         data_val_i,
  output logic [N_SRC-1:0]         gnt_o,
  output logic [WORD_W-1:0]        deser_data_o,
  output logic                     deser_data_val_o,
  output logic [$clog2(N_SRC)-1:0] deser_src_o
);

  localparam int IDX_W = $clog2(N_SRC);
  // One extra bit so rr_ptr + offset cannot overflow before the wrap.
  localparam int PTR_W = IDX_W + 1;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  gidx;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  next_ptr;
  logic [PTR_W-1:0]  cand;
  logic              found;
  logic              acc_val;
  logic              abort;
  logic              core_clear;
  logic              word_done;
  logic [WORD_W-1:0] word;

  // Round-robin search: first requesting source at or after rr_ptr.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = PTR_W'(rr_ptr) + PTR_W'(i);
      if (cand >= PTR_W'(N_SRC)) begin
        cand = cand - PTR_W'(N_SRC);
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        pick  = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

  // Only the granted lane is ever looked at; a withdrawn request aborts only
  // in a cycle with no accepted bit, so a final bit always completes the word.
  assign acc_val    = (state == COLLECT) && data_val_i[gidx];
  assign abort      = (state == COLLECT) && !req_i[gidx] && !data_val_i[gidx];
  assign core_clear = (state != COLLECT) || abort;
  assign next_ptr   = (gidx == IDX_W'(N_SRC - 1)) ? '0 : gidx + 1'b1;

  deser_shift_core #(
    .WORD_W (WORD_W)
  ) u_shift_core (
    .clk       (clk_i),
    .reset     (srst_i),
    .clear     (core_clear),
    .data_bit  (data_i[gidx]),
    .bit_val   (acc_val),
    .word      (word),
    .word_done (word_done)
  );

  // Grant/collect FSM with registered grant, word, source and strobe.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state            <= IDLE;
      gnt_o            <= '0;
      gidx             <= '0;
      rr_ptr           <= '0;
      deser_data_o     <= '0;
      deser_data_val_o <= 1'b0;
      deser_src_o      <= '0;
    end else begin
      deser_data_val_o <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gidx  <= pick;
            gnt_o <= {{(N_SRC-1){1'b0}}, 1'b1} << pick;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (word_done) begin
            deser_data_o     <= word;
            deser_data_val_o <= 1'b1;
            deser_src_o      <= gidx;
            gnt_o            <= '0;
            rr_ptr           <= next_ptr;
            state            <= IDLE;
          end else if (abort) begin
            gnt_o  <= '0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deser_arbiter.sv
// tb/tb_deser_arbiter.sv - directed self-checking bench for deser_arbiter
module tb_deser_arbiter;

  logic        clk = 1'b0;
  logic        srst_i;
  logic [3:0]  req_i;
  logic [3:0]  data_i;
  logic [3:0]  data_val_i;
  logic [3:0]  gnt_o;
  logic [15:0] deser_data_o;
  logic        deser_data_val_o;
  logic [1:0]  deser_src_o;

  int vectors     = 0;
  int miscompares = 0;

  deser_arbiter #(
    .N_SRC  (4),
    .WORD_W (16)
  ) dut (
    .clk_i            (clk),
    .srst_i           (srst_i),
    .req_i            (req_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .gnt_o            (gnt_o),
    .deser_data_o     (deser_data_o),
    .deser_data_val_o (deser_data_val_o),
    .deser_src_o      (deser_src_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive nbits consecutive valid bits MSB-first on one lane.
  task automatic send_bits(input logic [1:0] lane, input logic [15:0] w,
                           input int nbits, input bit drop_last);
    logic [15:0] sw;
    sw = w;
    for (int i = 0; i < nbits; i++) begin
      data_i           = '0;
      data_val_i       = '0;
      data_i[lane]     = sw[15];
      data_val_i[lane] = 1'b1;
      sw               = sw << 1;
      if (drop_last && i == nbits - 1) req_i[lane] = 1'b0;
      tick();
    end
    data_i     = '0;
    data_val_i = '0;
  endtask

  initial begin
    logic [1:0]  lane;
    logic [15:0] w;
    logic [15:0] sw;
    int          accepted;
    int          cycle;
    int          glitch;

    srst_i     = 1'b1;
    req_i      = '0;
    data_i     = '0;
    data_val_i = '0;
    tick();
    tick();
    check("rst_gnt",  gnt_o, 4'b0000);
    check("rst_val",  deser_data_val_o, 1'b0);
    check("rst_data", deser_data_o, 16'h0000);
    check("rst_src",  deser_src_o, 2'd0);
    srst_i = 1'b0;
    tick();
    check("idle_no_req_gnt", gnt_o, 4'b0000);

    // single source word 0xA5C3 on lane 2
    req_i = 4'b0100;
    tick();
    check("single_gnt", gnt_o, 4'b0100);
    send_bits(2'd2, 16'hA5C3, 16, 1'b0);
    check("single_val",  deser_data_val_o, 1'b1);
    check("single_data", deser_data_o, 16'hA5C3);
    check("single_src",  deser_src_o, 2'd2);
    check("single_gnt_off", gnt_o, 4'b0000);
    req_i = '0;
    tick();
    check("single_pulse", deser_data_val_o, 1'b0);
    check("single_hold",  deser_data_o, 16'hA5C3);

    // round-robin from a fresh pointer, all sources requesting
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    req_i  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      lane = 2'(k % 4);
      w    = 16'h1111 * 16'(lane);
      tick();
      check("rr_gnt", gnt_o, 4'b0001 << lane);
      check("rr_no_strobe", deser_data_val_o, 1'b0);
      send_bits(lane, w, 16, 1'b0);
      check("rr_val",  deser_data_val_o, 1'b1);
      check("rr_data", deser_data_o, w);
      check("rr_src",  deser_src_o, lane);
    end

    // abort: source 1 sends 7 bits then withdraws, source 2 next
    req_i = 4'b0110;
    tick();
    check("abort_gnt1", gnt_o, 4'b0010);
    send_bits(2'd1, 16'h0055, 7, 1'b0);
    req_i = 4'b0100;
    tick();
    check("abort_gnt_off", gnt_o, 4'b0000);
    check("abort_no_strobe", deser_data_val_o, 1'b0);
    tick();
    check("abort_next_gnt", gnt_o, 4'b0100);
    req_i = '0;
    tick();
    check("abort2_gnt_off", gnt_o, 4'b0000);

    // gapped valid on lane 1 with random noise elsewhere; pointer is 3
    req_i = 4'b0010;
    tick();
    check("gap_gnt", gnt_o, 4'b0010);
    w        = 16'h3C96;
    sw       = w;
    accepted = 0;
    cycle    = 0;
    glitch   = 0;
    while (accepted < 16 && cycle < 64) begin
      data_i     = 4'($urandom);
      data_val_i = 4'($urandom);
      req_i      = 4'($urandom) | 4'b0010;
      if (cycle % 2 == 0) begin
        data_val_i[1] = 1'b1;
        data_i[1]     = sw[15];
        sw            = sw << 1;
        accepted++;
      end else begin
        data_val_i[1] = 1'b0;
      end
      tick();
      cycle++;
      if (accepted < 16 && (deser_data_val_o || gnt_o != 4'b0010)) glitch++;
    end
    check("gap_accepted", accepted, 16);
    check("gap_no_glitch", glitch, 0);
    check("gap_val",  deser_data_val_o, 1'b1);
    check("gap_data", deser_data_o, 16'h3C96);
    check("gap_src",  deser_src_o, 2'd1);
    req_i      = '0;
    data_i     = '0;
    data_val_i = '0;
    tick();
    check("gap_pulse", deser_data_val_o, 1'b0);

    // reset after 10 bits from source 3; pointer is 2
    req_i = 4'b1000;
    tick();
    check("rstmid_gnt", gnt_o, 4'b1000);
    send_bits(2'd3, 16'hFFFF, 10, 1'b0);
    srst_i        = 1'b1;
    data_i[3]     = 1'b1;
    data_val_i[3] = 1'b1;
    tick();
    check("rstmid_gnt_off", gnt_o, 4'b0000);
    check("rstmid_val",  deser_data_val_o, 1'b0);
    check("rstmid_data", deser_data_o, 16'h0000);
    check("rstmid_src",  deser_src_o, 2'd0);
    srst_i     = 1'b0;
    data_i     = '0;
    data_val_i = '0;
    req_i      = 4'b1010;
    tick();
    check("rstmid_ptr_zero", gnt_o, 4'b0010);
    req_i = 4'b1000;
    tick();
    check("rstmid_abort", gnt_o, 4'b0000);
    tick();
    check("rstmid_gnt3", gnt_o, 4'b1000);
    send_bits(2'd3, 16'h5A0F, 16, 1'b0);
    check("rstmid_word_val",  deser_data_val_o, 1'b1);
    check("rstmid_word_data", deser_data_o, 16'h5A0F);
    check("rstmid_word_src",  deser_src_o, 2'd3);
    req_i = '0;
    tick();

    // request withdrawn together with the final bit still completes
    req_i = 4'b0001;
    tick();
    check("simul_gnt", gnt_o, 4'b0001);
    send_bits(2'd0, 16'hC001, 16, 1'b1);
    check("simul_val",  deser_data_val_o, 1'b1);
    check("simul_data", deser_data_o, 16'hC001);
    check("simul_src",  deser_src_o, 2'd0);
    tick();
    check("simul_pulse", deser_data_val_o, 1'b0);
    check("simul_gnt_off", gnt_o, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/deser_arbiter.md
DESER_ARBITER -- requirements
Module: deser_arbiter

Interface
REQ-001 Parameter N_SRC, default 4, SHALL set the number of serial sources (2..8).
REQ-002 Parameter WORD_W, default 16, SHALL set the deserialized word width.
REQ-003 clk_i  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 srst_i  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 req_i  input  N_SRC  SHALL be the per-source request to send one word.
REQ-006 data_i  input  N_SRC  SHALL be the per-source serial data bit.
REQ-007 data_val_i  input  N_SRC  SHALL be the per-source bit-valid qualifier.
REQ-008 gnt_o  output  N_SRC  SHALL be the one-hot grant; at most one bit set.
REQ-009 deser_data_o  output  WORD_W  SHALL be the last completed word.
REQ-010 deser_data_val_o  output  1  SHALL be the one-cycle word-complete strobe.
REQ-011 deser_src_o  output  $clog2(N_SRC)  SHALL be the source index of deser_data_o.

Function
REQ-012 FSM SHALL have states IDLE and COLLECT.
REQ-013 IDLE: when any req_i is set, the source is chosen round-robin starting at pointer rr_ptr; gnt_o bit set and state COLLECT on the next edge.
REQ-014 IDLE with req_i all zero SHALL remain IDLE with gnt_o = 0.
REQ-015 COLLECT: bit accepted only when data_val_i[granted] = 1; data_i[granted] shifted in at LSB, so the first accepted bit ends at MSB.
REQ-016 data_i/data_val_i of non-granted sources SHALL be ignored in all states; all inputs SHALL be ignored in IDLE.
REQ-017 Bit counter SHALL count accepted bits 0..WORD_W-1 and clear on word completion, abort and reset.
REQ-018 Acceptance of bit WORD_W at edge T SHALL produce: at T+1 deser_data_val_o = 1, deser_data_o = word, deser_src_o = granted index, gnt_o = 0, state IDLE.
REQ-019 deser_data_val_o SHALL be a single-cycle pulse; deser_data_o and deser_src_o SHALL hold until the next completed word.
REQ-020 Earliest next grant after completion at T SHALL be T+2; back-to-back words from the same source SHALL be legal.
REQ-021 Abort: req_i[granted] = 0 in COLLECT with no accepted bit that cycle SHALL discard the partial word, raise no strobe, and return to IDLE with gnt_o = 0 on the next edge.
REQ-022 req_i[granted] = 0 in the same cycle as the final valid bit SHALL complete the word normally (completion wins).
REQ-023 After completion or abort, rr_ptr SHALL become (granted + 1) mod N_SRC.
REQ-024 Gaps in data_val_i during COLLECT SHALL be tolerated without limit while req_i[granted] remains set.
REQ-025 A change in req_i of other sources during COLLECT SHALL NOT affect the current grant.

Reset
REQ-026 srst_i SHALL set state IDLE, gnt_o = 0, deser_data_val_o = 0, deser_data_o = 0, deser_src_o = 0, bit counter = 0, rr_ptr = 0.
REQ-027 srst_i asserted mid-word SHALL discard the partial word with no strobe; srst_i has priority over all other events.

Structure
REQ-028 Package deser_arb_pkg SHALL hold the FSM state enum and the default N_SRC/WORD_W constants.
REQ-029 Shift register plus bit counter SHALL be a sub-module deser_shift_core (ports: clk, reset, clear, bit, bit_val, word, word_done); arbitration, grant and FSM stay in the top.

Verification
REQ-030 Single source: req_i = 4'b0100, 16 valid bits 0xA5C3 MSB-first -> gnt_o = 4'b0100 one cycle after req; deser_data_o = 16'hA5C3, deser_src_o = 2, one-cycle strobe.
REQ-031 Round-robin: req_i = 4'b1111 held, each source sends its index replicated (0x0000, 0x1111, ...) -> grant order 0,1,2,3,0; the src/word pairs match.
REQ-032 Abort: source 1 sends 7 bits then drops req_i -> no strobe, gnt_o = 0 next cycle, the next grant goes to source 2 if it is requesting.
REQ-033 Gapped/noisy input: data_val_i[granted] toggles every cycle while non-granted lanes drive random valid bits -> word equals the granted stream only; strobe one cycle after the 16th accepted bit.
REQ-034 Reset mid-word: srst_i after 10 bits -> all outputs zero, no strobe, rr_ptr = 0; a following full word from source 3 completes correctly.
REQ-035 Simultaneous: req drop coinciding with the 16th bit -> word delivered with a strobe (REQ-022).
